// File: rtl/mux_dest_if.sv
// Source/sink bundle of the two-way destination mux:
// two show-ahead FIFO heads in, one registered stream out.
interface mux_dest_if #(
   parameter int BW = 6
);
   logic          empty_s0;
   logic [BW-1:0] data_s0;
   logic          pop_s0;
   logic          empty_s1;
   logic [BW-1:0] data_s1;
   logic          pop_s1;
   logic          almost_full_out;
   logic [BW-1:0] data_out;
   logic          valid_out;

   modport master (
      input  empty_s0, data_s0,
      input  empty_s1, data_s1,
      input  almost_full_out,
      output pop_s0, pop_s1,
      output data_out, valid_out
   );

   modport slave (
      output empty_s0, data_s0,
      output empty_s1, data_s1,
      output almost_full_out,
      input  pop_s0, pop_s1,
      input  data_out, valid_out
   );
endinterface

// File: rtl/mux_dest.sv
// Merges two destination FIFOs into one tagged, registered stream
// using burst-limited round-robin and downstream almost-full.
module mux_dest #(
   parameter int BW       = 6,
   parameter int DEST_BIT = 4,
   parameter int BURST    = 4
) (
   input  logic      clk,
   input  logic      reset_L,
   mux_dest_if.master bus
);
   localparam int CW = $clog2(BURST + 1);

   typedef enum logic [1:0] {IDLE, S0, S1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          g0, g1;
   logic          go, e0, e1;
   logic          pick1;
   logic [BW-1:0] word_d;

   assign e0 = bus.empty_s0;
   assign e1 = bus.empty_s1;
   assign go = reset_L && !bus.almost_full_out;

   // With both heads ready, stay with the owner until it has used its burst
   assign pick1 = (state_q == S1 && cnt_q != CW'(BURST)) ||
                  (state_q == S0 && cnt_q == CW'(BURST));

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      unique case (1'b1)
         !go:              ;
         go && e0 && e1:   ;
         go && !e0 && e1:  g0 = 1'b1;
         go && e0 && !e1:  g1 = 1'b1;
         go && !e0 && !e1: begin
            g1 = pick1;
            g0 = !pick1;
         end
         default:          ;
      endcase
   end

   assign bus.pop_s0 = g0;
   assign bus.pop_s1 = g1;

   always_comb begin
      word_d = '0;
      if (g0) begin
         word_d           = bus.data_s0;
         word_d[DEST_BIT] = 1'b0;
      end else if (g1) begin
         word_d           = bus.data_s1;
         word_d[DEST_BIT] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (1'b1)
         g0: begin
            if (state_q == S0) begin
               if (cnt_q != CW'(BURST)) cnt_d = cnt_q + CW'(1);
            end else begin
               state_d = S0;
               cnt_d   = CW'(1);
            end
         end
         g1: begin
            if (state_q == S1) begin
               if (cnt_q != CW'(BURST)) cnt_d = cnt_q + CW'(1);
            end else begin
               state_d = S1;
               cnt_d   = CW'(1);
            end
         end
         default: begin
            // Fairness restarts only on a true idle, never during a stall
            if (!bus.almost_full_out && e0 && e1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         bus.data_out  <= '0;
         bus.valid_out <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bus.data_out  <= word_d;
         bus.valid_out <= g0 | g1;
      end
   end
endmodule

// File: tb/tb_mux_dest.sv
// Bench for mux_dest: queue-backed FIFOs and an owner/run-length
// arbitration model, directed cases followed by random traffic.
module tb_mux_dest;
   localparam int BW       = 6;
   localparam int DEST_BIT = 4;
   localparam int BURST    = 4;

   logic clk;
   logic reset_L;

   mux_dest_if #(.BW(BW)) bus ();

   mux_dest #(
      .BW(BW),
      .DEST_BIT(DEST_BIT),
      .BURST(BURST)
   ) dut (
      .clk(clk),
      .reset_L(reset_L),
      .bus(bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];
   int            glog[$];
   int            owner;
   int            run;
   int            checks;
   int            failures;

   task automatic chk(input string tag, input logic [BW-1:0] obs,
                      input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(bit e0, bit e1, bit af);
      if (af) return -1;
      if (!e0 && !e1) begin
         if (owner < 0) return 0;
         if (run < BURST) return owner;
         return 1 - owner;
      end
      if (!e0) return 0;
      if (!e1) return 1;
      return -1;
   endfunction

   task automatic drive(input bit af);
      bus.empty_s0        = (q0.size() == 0);
      bus.data_s0         = (q0.size() != 0) ? q0[0] : '0;
      bus.empty_s1        = (q1.size() == 0);
      bus.data_s1         = (q1.size() != 0) ? q1[0] : '0;
      bus.almost_full_out = af;
   endtask

   task automatic step(input bit af);
      int            g;
      bit            e0;
      bit            e1;
      logic [BW-1:0] w;
      logic [BW-1:0] exp_data;
      logic          exp_valid;
      @(negedge clk);
      drive(af);
      #1;
      e0 = (q0.size() == 0);
      e1 = (q1.size() == 0);
      g  = model_grant(e0, e1, af);
      chk("pop_s0", BW'(bus.pop_s0), BW'(g == 0));
      chk("pop_s1", BW'(bus.pop_s1), BW'(g == 1));
      exp_data  = '0;
      exp_valid = 1'b0;
      if (g >= 0) begin
         w = (g == 0) ? q0.pop_front() : q1.pop_front();
         w[DEST_BIT] = (g == 1);
         exp_data  = w;
         exp_valid = 1'b1;
         glog.push_back(g);
         if (g == owner) begin
            if (run < BURST) run++;
         end else begin
            owner = g;
            run   = 1;
         end
      end else if (!af && e0 && e1) begin
         owner = -1;
         run   = 0;
      end
      @(posedge clk);
      #1;
      chk("data_out", bus.data_out, exp_data);
      chk("valid_out", BW'(bus.valid_out), BW'(exp_valid));
   endtask

   initial begin
      int base;
      int n;
      checks   = 0;
      failures = 0;
      owner    = -1;
      run      = 0;
      reset_L  = 1'b0;
      drive(1'b0);

      // power-on reset
      @(negedge clk);
      #1;
      chk("rst_data", bus.data_out, '0);
      chk("rst_valid", BW'(bus.valid_out), '0);
      chk("rst_pops", BW'({bus.pop_s1, bus.pop_s0}), '0);
      reset_L = 1'b1;

      // single source s0, tag bit cleared
      q0.push_back(6'h2A);
      q0.push_back(6'h15);
      step(1'b0);
      chk("t2_w0", bus.data_out, 6'h2A);
      step(1'b0);
      chk("t2_w1", bus.data_out, 6'h05);
      step(1'b0);

      // single source s1, tag bit set
      q1.push_back(6'h03);
      step(1'b0);
      chk("t3_retag", bus.data_out, 6'h13);
      step(1'b0);

      // both full, burst round robin with a 3-cycle stall
      for (int i = 0; i < 12; i++) begin
         q0.push_back(BW'($urandom));
         q1.push_back(BW'($urandom));
      end
      base = glog.size();
      for (int i = 0; i < 6; i++) step(1'b0);
      for (int i = 0; i < 3; i++) step(1'b1);
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
         step(1'b0);
         n++;
      end
      chk("burst_len", BW'(glog.size() - base), BW'(24));
      for (int k = 0; k < 24; k++) begin
         if (base + k < glog.size())
            chk($sformatf("burst_%0d", k), BW'(glog[base + k]),
                BW'((k / 4) % 2));
      end

      // drained: refill both together, s0 wins
      step(1'b0);
      q0.push_back(BW'($urandom));
      q1.push_back(BW'($urandom));
      base = glog.size();
      step(1'b0);
      chk("refill_n", BW'(glog.size() - base), BW'(1));
      if (glog.size() > base) chk("refill_s0", BW'(glog[base]), '0);
      step(1'b0);
      step(1'b0);

      // random traffic and backpressure
      for (int i = 0; i < 300; i++) begin
         if (q0.size() < 8 && $urandom_range(0, 9) < 4)
            q0.push_back(BW'($urandom));
         if (q1.size() < 8 && $urandom_range(0, 9) < 4)
            q1.push_back(BW'($urandom));
         step($urandom_range(0, 9) < 2);
      end

      // reset mid-traffic: no edge needed to clear outputs and pops
      q0.push_back(BW'($urandom));
      q0.push_back(BW'($urandom));
      q1.push_back(BW'($urandom));
      step(1'b0);
      @(negedge clk);
      drive(1'b0);
      reset_L = 1'b0;
      #1;
      chk("mid_rst_data", bus.data_out, '0);
      chk("mid_rst_valid", BW'(bus.valid_out), '0);
      chk("mid_rst_pops", BW'({bus.pop_s1, bus.pop_s0}), '0);
      owner = -1;
      run   = 0;
      @(negedge clk);
      reset_L = 1'b1;
      for (int i = 0; i < 12; i++) step(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
